// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU/OAM-DMA bus arbiter with boot overlay, FF46/FF50 registers and HRAM
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [7:0]  bus_wdata,
  output logic        bus_boot,
  input  logic [7:0]  bus_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active,
  output logic        boot_en
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [7:0] DMA_LEN = 8'd160;

  logic [0:0] state;
  logic [7:0] idx;
  logic [7:0] dma_reg;
  logic [7:0] src_page;
  logic [7:0] rdata_q;
  logic       fwd_pend;
  logic [7:0] hram [0:126];

  logic hit_dma, hit_boot, hit_hram, internal;
  logic cpu_read, cpu_write, dma_reading;

  // Address decode; a simultaneous rd+wr is handled as a write
  always_comb begin
    hit_dma     = (cpu_addr == 16'hFF46);
    hit_boot    = (cpu_addr == 16'hFF50);
    hit_hram    = (cpu_addr[15:7] == 9'h1FF) && (cpu_addr[6:0] != 7'h7F);
    internal    = hit_dma | hit_boot | hit_hram;
    cpu_write   = cpu_wr;
    cpu_read    = cpu_rd & ~cpu_wr;
    dma_active  = (state == ST_RUN);
    dma_reading = dma_active && (idx != DMA_LEN);
  end

  // Bus owner mux: DMA owns the bus for its whole run, otherwise forwarded CPU accesses pass through
  always_comb begin
    bus_addr  = cpu_addr;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_wdata = cpu_wdata;
    bus_boot  = 1'b0;
    if (dma_active) begin
      bus_addr  = {src_page, idx};
      bus_rd    = dma_reading;
      bus_wdata = 8'h00;
    end else if (!internal) begin
      bus_rd   = cpu_read;
      bus_wr   = cpu_write;
      bus_boot = boot_en & cpu_read & (cpu_addr[15:8] == 8'h00);
    end
  end

  // Forwarded reads arrive from the bus one cycle late, so they bypass the local read register
  always_comb begin
    cpu_rdata = fwd_pend ? bus_rdata : rdata_q;
    oam_wdata = bus_rdata;
  end

  // OAM DMA engine: 160 reads, trailing OAM write, restart on any FF46 write
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 8'd0;
      dma_reg  <= 8'h00;
      src_page <= 8'h00;
      oam_wr   <= 1'b0;
      oam_addr <= 8'h00;
    end else begin
      oam_wr   <= dma_reading;
      oam_addr <= idx;
      if (cpu_write && hit_dma) begin
        dma_reg  <= cpu_wdata;
        src_page <= (cpu_wdata < 8'hE0) ? cpu_wdata : cpu_wdata - 8'h20;
        state    <= ST_RUN;
        idx      <= 8'd0;
      end else if (dma_active) begin
        if (idx == DMA_LEN) begin
          state <= ST_IDLE;
          idx   <= 8'd0;
        end else begin
          idx <= idx + 8'd1;
        end
      end
    end
  end

  // Boot overlay flag: cleared by a nonzero FF50 write, only reset brings it back
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_en <= 1'b1;
    end else if (cpu_write && hit_boot && (cpu_wdata != 8'h00)) begin
      boot_en <= 1'b0;
    end
  end

  // HRAM storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (cpu_write && hit_hram) begin
      hram[cpu_addr[6:0]] <= cpu_wdata;
    end
  end

  // CPU read register: internal sources registered here, forwarded reads captured once they land
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 8'hFF;
      fwd_pend <= 1'b0;
    end else begin
      if (fwd_pend) begin
        rdata_q <= bus_rdata;
      end
      fwd_pend <= 1'b0;
      if (cpu_read) begin
        if (hit_dma) begin
          rdata_q <= dma_reg;
        end else if (hit_boot) begin
          rdata_q <= 8'hFF;
        end else if (hit_hram) begin
          rdata_q <= hram[cpu_addr[6:0]];
        end else if (dma_active) begin
          rdata_q <= 8'hFF;
        end else begin
          fwd_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic [7:0]  cpu_rdata;
  logic [15:0] bus_addr;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic        bus_boot;
  logic [7:0]  bus_rdata = 8'h00;
  logic [7:0]  oam_addr;
  logic        oam_wr;
  logic [7:0]  oam_wdata;
  logic        dma_active;
  logic        boot_en;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_boot(bus_boot), .bus_rdata(bus_rdata),
    .oam_addr(oam_addr), .oam_wr(oam_wr), .oam_wdata(oam_wdata),
    .dma_active(dma_active), .boot_en(boot_en)
  );

  logic [7:0]  mem    [0:65535];
  logic [7:0]  boot_m [0:255];
  logic [7:0]  hram_m [0:127];

  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] dmaq [$];
  logic [15:0] oamq [$];
  logic [7:0]  rdq  [$];
  bit          rd_pend = 0;
  logic        exp_boot = 1'b1;
  logic [7:0]  exp_ff46 = 8'h00;
  int          dma_left = 0;
  int          dma_cnt  = 0;
  logic [15:0] mon_e;

  // External memory with registered read data
  always @(posedge clk) begin
    if (bus_wr) mem[bus_addr] = bus_wdata;
    if (bus_rd) bus_rdata <= bus_boot ? boot_m[bus_addr[7:0]] : mem[bus_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_hram(input logic [15:0] a);
    return (a[15:7] == 9'h1FF) && (a[6:0] != 7'h7F);
  endfunction

  // DMA-side scoreboard: bus read addresses and OAM writes
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dma_active) dma_cnt++;
      if (oam_wr) begin
        if (oamq.size() == 0) begin
          check("oam_extra", oam_wr, 0);
        end else begin
          mon_e = oamq.pop_front();
          check("oam_addr", oam_addr, mon_e[15:8]);
          check("oam_wdata", oam_wdata, mon_e[7:0]);
        end
      end
      if (dma_active && bus_rd) begin
        check("dma_boot", bus_boot, 0);
        if (dmaq.size() == 0) check("dma_extra", bus_rd, 0);
        else check("dma_addr", bus_addr, dmaq.pop_front());
      end
    end
  end

  task automatic cyc(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
    logic internal, exp_dma, exb;
    logic [7:0] ex, s;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    exp_dma  = (dma_left > 0);
    internal = (a == 16'hFF46) || (a == 16'hFF50) || is_hram(a);
    @(negedge clk);
    if (rd_pend) begin
      check("cpu_rdata", cpu_rdata, rdq.pop_front());
      rd_pend = 0;
    end
    check("dma_active", dma_active, exp_dma);
    check("boot_en", boot_en, exp_boot);
    if (rd && !wr) begin
      if (a == 16'hFF46) ex = exp_ff46;
      else if (a == 16'hFF50) ex = 8'hFF;
      else if (is_hram(a)) ex = hram_m[a[6:0]];
      else if (exp_dma) ex = 8'hFF;
      else begin
        exb = exp_boot && (a < 16'h0100);
        check("bus_rd", bus_rd, 1);
        check("bus_addr", bus_addr, a);
        check("bus_boot", bus_boot, exb);
        ex = exb ? boot_m[a[7:0]] : mem[a];
      end
      rdq.push_back(ex);
      rd_pend = 1;
    end else if (wr) begin
      if (is_hram(a)) hram_m[a[6:0]] = d;
      else if (!internal) begin
        if (exp_dma) check("bus_wr_drop", bus_wr, 0);
        else begin
          check("bus_wr", bus_wr, 1);
          check("bus_waddr", bus_addr, a);
          check("bus_wdata", bus_wdata, d);
        end
      end
    end else if (!exp_dma) begin
      check("bus_rd_idle", bus_rd, 0);
      check("bus_wr_idle", bus_wr, 0);
    end
    @(posedge clk); #1;
    if (wr && a == 16'hFF46) begin
      exp_ff46 = d;
      s = (d < 8'hE0) ? d : d - 8'h20;
      dmaq.delete();
      while (oamq.size() > 1) void'(oamq.pop_back());
      for (int i = 0; i < 160; i++) begin
        dmaq.push_back({s, i[7:0]});
        oamq.push_back({i[7:0], mem[{s, i[7:0]}]});
      end
      dma_left = 161;
    end else if (dma_left > 0) begin
      dma_left--;
    end
    if (wr && a == 16'hFF50 && d != 8'h00) exp_boot = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dmaq.delete(); oamq.delete(); rdq.delete();
    rd_pend = 0; exp_boot = 1'b1; exp_ff46 = 8'h00; dma_left = 0;
  endtask

  task automatic run_out_dma();
    while (dma_left > 0) idle();
    repeat (3) idle();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ i[15:8] ^ 8'h33;
    for (int i = 0; i < 256; i++) begin
      boot_m[i] = ~i[7:0];
      mem[16'hC000 + i] = i[7:0] ^ 8'h5A;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 8'hFF);
    check("rst_dma_active", dma_active, 0);
    check("rst_oam_wr", oam_wr, 0);
    check("rst_boot_en", boot_en, 1);
    check("rst_bus_rd", bus_rd, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_boot", bus_boot, 0);
    @(posedge clk); #1;

    cyc(1'b1, 1'b0, 16'h0005, 8'h00);
    idle();
    cyc(1'b0, 1'b1, 16'hFF50, 8'h01);
    cyc(1'b1, 1'b0, 16'h0005, 8'h00);
    cyc(1'b0, 1'b1, 16'hFF50, 8'h00);
    idle();
    cyc(1'b1, 1'b0, 16'hFF46, 8'h00);
    cyc(1'b1, 1'b0, 16'hFF50, 8'h00);
    cyc(1'b0, 1'b1, 16'hA000, 8'h3C);
    cyc(1'b1, 1'b1, 16'hA002, 8'hC3);
    cyc(1'b1, 1'b0, 16'hA000, 8'h00);
    cyc(1'b1, 1'b0, 16'hA002, 8'h00);
    cyc(1'b0, 1'b1, 16'hFF80, 8'h12);
    cyc(1'b0, 1'b1, 16'hFFFE, 8'h34);
    cyc(1'b0, 1'b1, 16'hFFFF, 8'h09);
    cyc(1'b1, 1'b0, 16'hFFFE, 8'h00);
    cyc(1'b1, 1'b0, 16'hFF80, 8'h00);
    cyc(1'b1, 1'b0, 16'hFFFF, 8'h00);
    idle();

    dma_cnt = 0;
    cyc(1'b0, 1'b1, 16'hFF46, 8'hC0);
    repeat (160) idle();
    cyc(1'b0, 1'b1, 16'hFF46, 8'hE1);
    check("dma_c0_cycles", dma_cnt, 161);
    dma_cnt = 0;
    repeat (10) idle();
    cyc(1'b1, 1'b0, 16'h1234, 8'h00);
    cyc(1'b0, 1'b1, 16'hA001, 8'h55);
    cyc(1'b0, 1'b1, 16'hFF90, 8'h77);
    cyc(1'b1, 1'b0, 16'hFF90, 8'h00);
    cyc(1'b1, 1'b0, 16'hFF46, 8'h00);
    run_out_dma();
    check("dma_e1_cycles", dma_cnt, 161);
    check("oam_left_e1", oamq.size(), 0);
    check("dma_left_e1", dmaq.size(), 0);
    cyc(1'b1, 1'b0, 16'hA001, 8'h00);
    idle();

    cyc(1'b0, 1'b1, 16'hFF46, 8'hC0);
    repeat (50) idle();
    cyc(1'b0, 1'b1, 16'hFF46, 8'hD0);
    dma_cnt = 0;
    run_out_dma();
    check("dma_restart_cycles", dma_cnt, 161);
    check("oam_left_restart", oamq.size(), 0);
    check("dma_left_restart", dmaq.size(), 0);

    cyc(1'b0, 1'b1, 16'hFF46, 8'hC0);
    repeat (80) idle();
    do_reset();
    repeat (5) idle();
    cyc(1'b1, 1'b0, 16'hFF46, 8'h00);
    cyc(1'b1, 1'b0, 16'h0005, 8'h00);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory bus controller between the CPU core and the shared external memory bus (cartridge ROM, boot ROM, WRAM, VRAM, I/O). It gives the bus to either the CPU or the built-in OAM DMA engine, owns the boot-ROM overlay flag (FF50) and the 127-byte HRAM (FF80–FFFE), and drives a dedicated OAM write port for DMA. All bus reads have one-cycle latency, matching the registered ROM model.

## Interface

- No parameters.
- clk  in  1  system clock; one bus access per cycle
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  16  CPU address
- cpu_rd  in  1  CPU read request (single-cycle)
- cpu_wr  in  1  CPU write request (single-cycle)
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid the cycle after cpu_rd
- bus_addr  out  16  external bus address
- bus_rd  out  1  external read strobe
- bus_wr  out  1  external write strobe
- bus_wdata  out  8  external write data
- bus_boot  out  1  qualifies bus_rd: select boot ROM instead of cartridge
- bus_rdata  in  8  external read data, valid the cycle after bus_rd
- oam_addr  out  8  OAM write index 0x00–0x9F
- oam_wr  out  1  OAM write strobe
- oam_wdata  out  8  OAM write data
- dma_active  out  1  DMA owns the bus this cycle
- boot_en  out  1  boot-ROM overlay enabled

## Operation

- Internal decode: FF46 (DMA register), FF50 (boot disable), FF80–FFFE (HRAM). These addresses are never forwarded to the bus. FFFF and everything else are forwarded.
- cpu_rd and cpu_wr both high: treated as a write.
- CPU reads:
  - FF46 returns the last value written (reset 0x00).
  - FF50 returns 0xFF.
  - HRAM returns the stored byte.
  - Forwarded reads return bus_rdata.
  - No access in the previous cycle: cpu_rdata holds its last value.
- Boot overlay: bus_boot = boot_en & (cpu_addr < 0x0100) on CPU reads. It is always 0 on DMA reads.
- FF50 write with nonzero data clears boot_en. boot_en stays clear until rst. A zero write has no effect.
- DMA states: IDLE, RUN. The byte counter idx runs 0..160.
  - CPU write V to FF46 in cycle N: store V, enter RUN at N+1 with idx = 0.
  - Source page S = V for V < 0xE0, otherwise V − 0x20 (echo mirror).
  - RUN, each cycle: bus_rd = 1, bus_addr = {S, idx}, idx++.
  - One cycle after each DMA read: oam_wr = 1, oam_addr = idx−1, oam_wdata = bus_rdata.
  - After the read at idx = 159, the next cycle performs only the final OAM write, then returns to IDLE.
- CPU during DMA (dma_active = 1):
  - HRAM, FF46 and FF50 accesses work normally.
  - Forwarded reads return 0xFF and generate no bus strobe.
  - Forwarded writes are dropped.
- FF46 write during RUN: restart from idx = 0 with the new S on the next cycle. The OAM write still pending from the previous read completes.
- Not in DMA: bus_addr/bus_rd/bus_wr/bus_wdata are combinational pass-through of the CPU request for forwarded addresses. Strobes are 0 otherwise.
- Bus owner mux: DMA wins every cycle dma_active = 1.

## Timing

- Reset values: bus_rd = 0, bus_wr = 0, bus_boot = 0, oam_wr = 0, dma_active = 0, boot_en = 1, cpu_rdata = 0xFF, FF46 register = 0x00, idx = 0, state IDLE. HRAM contents are not reset.
- rst mid-DMA: the next cycle is IDLE, and there are no further oam_wr or bus_rd pulses.
- FF46 write at N:
  - dma_active high N+1 … N+161 (161 cycles).
  - DMA bus_rd N+1 … N+160.
  - oam_wr N+2 … N+161.
  - The CPU regains the bus at N+162.
- CPU read latency: 1 cycle for every source (bus, HRAM, registers).
- FF50 write at N: boot_en = 0 from N+1. A CPU read of 0x0000 at N+1 has bus_boot = 0.
- Simultaneous FF46 write and final DMA cycle (N+161): final OAM write occurs, then a new RUN starts at N+162.

## Test plan

- Reset, CPU reads 0x0005 → bus_rd = 1, bus_boot = 1, bus_addr = 0x0005; cpu_rdata = bus_rdata one cycle later.
- Write 0x01 to FF50, then read 0x0005 → bus_boot = 0; boot_en = 0; a later write of 0x00 to FF50 leaves boot_en = 0.
- Preload 0xC000–0xC09F with the pattern i^0x5A, write 0xC0 to FF46 → 160 oam_wr pulses, oam_wdata[i] = i^0x5A, dma_active high exactly 161 cycles.
- During DMA:
  - CPU read of 0x1234 → cpu_rdata = 0xFF, no CPU bus strobe.
  - CPU write 0x77 to 0xFF90, then read 0xFF90 → 0x77.
- Write 0xE1 to FF46 → DMA reads 0xC100–0xC19F; FF46 read returns 0xE1.
- Restart at idx 50 with 0xD0 → reads resume at 0xD000, 161 more dma_active cycles.
- rst at idx 80 → no oam_wr after the next cycle, dma_active = 0, boot_en = 1.
